// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter sharing one registered GMII transmit bus between NUM_PORTS frame sources.
// Optional frame-length watchdog: define GMII_ARB_WATCHDOG_EN.
module gmii_tx_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int IFG_BYTES       = 12,
    parameter int START_TIMEOUT   = 16,
    parameter int MAX_FRAME_BYTES = 1530
) (
    input  logic                   clk_mac,
    input  logic                   rst_n,
    input  logic [NUM_PORTS-1:0]   src_req,
    input  logic [NUM_PORTS-1:0]   src_en,
    input  logic [NUM_PORTS-1:0]   src_er,
    input  logic [8*NUM_PORTS-1:0] src_data,
    output logic [NUM_PORTS-1:0]   src_grant,
    output logic                   gmii_tx_en,
    output logic                   gmii_tx_er,
    output logic                   gmii_tx_dvalid,
    output logic [7:0]             gmii_tx_data,
    output logic [31:0]            frames_sent,
    output logic [15:0]            start_timeouts,
    output logic [15:0]            frames_truncated,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_IFG   = 2'd3;

    if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
        $error("gmii_tx_arbiter: NUM_PORTS must be 2..8");
    end
    if (IFG_BYTES < 1 || IFG_BYTES > 63) begin : g_bad_ifg
        $error("gmii_tx_arbiter: IFG_BYTES must be 1..63");
    end
    if (START_TIMEOUT < 2 || START_TIMEOUT > 255) begin : g_bad_timeout
        $error("gmii_tx_arbiter: START_TIMEOUT must be 2..255");
    end
    if (MAX_FRAME_BYTES < 1 || MAX_FRAME_BYTES > 65535) begin : g_bad_max_frame
        $error("gmii_tx_arbiter: MAX_FRAME_BYTES must be 1..65535");
    end

    // Handshake: a source raises src_req and holds it until its frame is done.
    // src_grant (one-hot) answers it; the source then has START_TIMEOUT cycles
    // to raise src_en, and ends the frame by dropping src_en, which also drops
    // the grant on that same edge. en must stay low until a new grant is seen.

    logic [1:0]       state;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] last_winner;
    logic [7:0]       wait_cnt;
    logic [5:0]       ifg_cnt;

    logic [7:0] src_byte [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_byte_lanes
        assign src_byte[p] = src_data[8*p +: 8];
    end

    logic       sel_req;
    logic       sel_en;
    logic       sel_er;
    logic [7:0] sel_data;

    assign sel_req  = src_req[sel];
    assign sel_en   = src_en[sel];
    assign sel_er   = src_er[sel];
    assign sel_data = src_byte[sel];

    // Scan upward from the port after the last winner so nobody wins twice
    // in a row while someone else is waiting.
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(last_winner) + k) % NUM_PORTS);
            if (!pick_valid && src_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    logic in_fwd_state;
    logic wd_hit;
    logic wd_trunc;

    assign in_fwd_state = (state == S_GRANT) || (state == S_FRAME);

`ifdef GMII_ARB_WATCHDOG_EN
    logic [15:0] byte_cnt;

    // wd_hit marks the byte that reaches the limit; wd_trunc cuts on the next edge.
    assign wd_hit   = in_fwd_state && sel_en && ((byte_cnt + 16'd1) == 16'(MAX_FRAME_BYTES));
    assign wd_trunc = (state == S_FRAME) && (byte_cnt == 16'(MAX_FRAME_BYTES));

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 16'd0;
        end else begin
            case (state)
                S_IDLE:  byte_cnt <= 16'd0;
                S_GRANT: if (sel_en) byte_cnt <= 16'd1;
                S_FRAME: if (sel_en && !wd_trunc) byte_cnt <= byte_cnt + 16'd1;
                default: byte_cnt <= byte_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            frames_truncated <= 16'd0;
        end else if (wd_trunc && frames_truncated != 16'hFFFF) begin
            frames_truncated <= frames_truncated + 16'd1;
        end
    end
`else
    assign wd_hit           = 1'b0;
    assign wd_trunc         = 1'b0;
    assign frames_truncated = 16'd0;
`endif

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            sel            <= '0;
            last_winner    <= IDX_W'(NUM_PORTS - 1);
            wait_cnt       <= 8'd0;
            ifg_cnt        <= 6'd0;
            src_grant      <= '0;
            frames_sent    <= 32'd0;
            start_timeouts <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        src_grant   <= NUM_PORTS'(1) << pick_idx;
                        sel         <= pick_idx;
                        last_winner <= pick_idx;
                        wait_cnt    <= 8'd0;
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (sel_en) begin
                        state <= S_FRAME;
                    end else if (!sel_req) begin
                        src_grant <= '0;
                        state     <= S_IDLE;
                    end else if (wait_cnt == 8'(START_TIMEOUT - 1)) begin
                        src_grant <= '0;
                        if (start_timeouts != 16'hFFFF) begin
                            start_timeouts <= start_timeouts + 16'd1;
                        end
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_FRAME: begin
                    if (wd_trunc) begin
                        src_grant <= '0;
                        ifg_cnt   <= 6'd0;
                        state     <= S_IFG;
                    end else if (!sel_en) begin
                        src_grant   <= '0;
                        frames_sent <= frames_sent + 32'd1;
                        ifg_cnt     <= 6'd0;
                        state       <= S_IFG;
                    end
                end
                S_IFG: begin
                    ifg_cnt <= ifg_cnt + 6'd1;
                    if (ifg_cnt == 6'(IFG_BYTES - 1)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered bus: one cycle from source byte to gmii_tx_*.
    logic fwd;
    assign fwd = in_fwd_state && !wd_trunc;

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            gmii_tx_en     <= 1'b0;
            gmii_tx_er     <= 1'b0;
            gmii_tx_dvalid <= 1'b0;
            gmii_tx_data   <= 8'h00;
        end else begin
            gmii_tx_en     <= fwd & sel_en;
            gmii_tx_er     <= fwd & (sel_er | wd_hit);
            gmii_tx_dvalid <= 1'b1;
            gmii_tx_data   <= fwd ? sel_data : 8'h00;
        end
    end

    assign dbg_state = state;

endmodule
